// File: rtl/adder_sequencer_if.sv
// Command handshake bundle for adder_sequencer: valid/ready plus opcode and immediate.
interface adder_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/adder_sequencer.sv
// Command-driven control sequencer for the 8-bit accumulator/B-register/ALU datapath.
// Sequences datapath strobes per command and latches ALU carry/zero after arithmetic.
module adder_sequencer (
    input  logic                clk,
    input  logic                rst,
    adder_sequencer_if.slave    cmd,
    input  logic                cf_in,
    input  logic                zf_in,
    output logic [7:0]          bus_data,
    output logic                n_la,
    output logic                n_lb,
    output logic                e_a,
    output logic                e_u,
    output logic                sub,
    output logic                out_sel,
    output logic                done,
    output logic                cf,
    output logic                zf,
    output logic                err,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_DONE,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LDA = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_OUT = 3'b100,
        OP_CLR = 3'b101,
        OP_HLT = 3'b110,
        OP_ILL = 3'b111
    } op_t;

    state_t     state_q;
    state_t     state_d;
    op_t        op_q;
    logic [7:0] data_q;
    logic       accept;

    assign cmd.cmd_ready = (state_q == S_IDLE) && !rst;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign done          = (state_q == S_DONE);
    assign halted        = (state_q == S_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            cf      <= 1'b0;
            zf      <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= op_t'(cmd.cmd_op);
                data_q <= cmd.cmd_data;
            end
            if (state_q == S_T1 && op_q == OP_ILL) begin
                err <= 1'b1;
            end
            // ALU flags are only meaningful while e_u drives the bus, i.e. in T3
            if (state_q == S_T3) begin
                cf <= cf_in;
                zf <= zf_in;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        bus_data = '0;
        n_la     = 1'b1;
        n_lb     = 1'b1;
        e_a      = 1'b0;
        e_u      = 1'b0;
        sub      = 1'b0;
        out_sel  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_T1;
                end
            end
            S_T1: begin
                case (op_q)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        bus_data = data_q;
                        state_d  = S_T2;
                    end
                    OP_CLR: state_d = S_T2;
                    OP_OUT: begin
                        e_a     = 1'b1;
                        out_sel = 1'b1;
                        state_d = S_DONE;
                    end
                    OP_HLT:  state_d = S_HALT;
                    default: state_d = S_DONE;
                endcase
            end
            S_T2: begin
                // Operand registered in T1 is on the bus now: B for arithmetic, A for loads
                if (op_q == OP_ADD || op_q == OP_SUB) begin
                    n_lb    = 1'b0;
                    state_d = S_T3;
                end else begin
                    n_la    = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_T3: begin
                e_u     = 1'b1;
                n_la    = 1'b0;
                sub     = (op_q == OP_SUB);
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_adder_sequencer.sv
// Self-checking bench: datapath model around the sequencer, random commands vs. reference model.
module tb_adder_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cf_in, zf_in;
    logic [7:0] bus_data;
    logic       n_la, n_lb, e_a, e_u, sub, out_sel;
    logic       done, cf, zf, err, halted;

    adder_sequencer_if cmd_if ();

    adder_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd_if.slave),
        .cf_in    (cf_in),
        .zf_in    (zf_in),
        .bus_data (bus_data),
        .n_la     (n_la),
        .n_lb     (n_lb),
        .e_a      (e_a),
        .e_u      (e_u),
        .sub      (sub),
        .out_sel  (out_sel),
        .done     (done),
        .cf       (cf),
        .zf       (zf),
        .err      (err),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    // Datapath: input buffer, A, B, ALU, shared bus, output mux
    logic [7:0] in_buf, a_reg, b_reg, bus, out_disp;
    logic [8:0] alu9;
    assign alu9     = sub ? ({1'b0, a_reg} - {1'b0, b_reg}) : ({1'b0, a_reg} + {1'b0, b_reg});
    assign cf_in    = alu9[8];
    assign zf_in    = (alu9[7:0] == 8'h00);
    assign bus      = e_u ? alu9[7:0] : (e_a ? a_reg : in_buf);
    assign out_disp = out_sel ? bus : a_reg;

    always @(posedge clk) begin
        in_buf <= bus_data;
        if (!n_la) a_reg <= bus;
        if (!n_lb) b_reg <= bus;
    end

    int n_checks = 0;
    int n_bad    = 0;
    int viol     = 0;

    always @(negedge clk) begin
        if (rst === 1'b0 && ((e_a && e_u) || (!n_la && !n_lb))) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] acc_ref;
    logic       cf_ref, zf_ref, err_ref;

    function automatic logic [13:0] ctrl_word();
        return {n_la, n_lb, e_a, e_u, sub, out_sel, bus_data};
    endfunction

    localparam logic [13:0] CTRL_IDLE = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int w = 0;
        while (cmd_if.cmd_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        chk("ready_wait", 32'(cmd_if.cmd_ready), 1);
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [7:0] data);
        int idx, lat, nla_cnt, nlb_at, eu_at, sub_cnt, ea_cnt, os_cnt, exp_lat;
        logic [7:0] bus1, shown, exp_bus1;
        logic       arith, load;
        wait_ready();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        tick();
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 3'($urandom);
        cmd_if.cmd_data  = 8'($urandom);
        lat = 0; nla_cnt = 0; nlb_at = 0; eu_at = 0; sub_cnt = 0; ea_cnt = 0; os_cnt = 0;
        bus1 = 8'h00; shown = 8'h00;
        for (idx = 1; idx <= 10; idx++) begin
            if (idx == 1) bus1 = bus_data;
            if (!n_la) nla_cnt++;
            if (!n_lb) nlb_at = idx;
            if (e_u) eu_at = idx;
            if (e_u && sub) sub_cnt++;
            if (e_a) begin
                ea_cnt++;
                shown = out_disp;
            end
            if (out_sel) os_cnt++;
            if (done) begin
                lat = idx;
                break;
            end
            tick();
        end
        arith = (op == 3'd2 || op == 3'd3);
        load  = (op == 3'd1 || op == 3'd5);
        case (op)
            3'd1: acc_ref = data;
            3'd5: acc_ref = 8'h00;
            3'd2: begin
                cf_ref  = (int'(acc_ref) + int'(data)) > 255;
                acc_ref = 8'((int'(acc_ref) + int'(data)) % 256);
                zf_ref  = (acc_ref == 0);
            end
            3'd3: begin
                cf_ref  = data > acc_ref;
                acc_ref = 8'((int'(acc_ref) - int'(data) + 256) % 256);
                zf_ref  = (acc_ref == 0);
            end
            3'd7: err_ref = 1'b1;
            default: ;
        endcase
        exp_lat  = arith ? 4 : (load ? 3 : 2);
        exp_bus1 = (arith || op == 3'd1) ? data : 8'h00;
        chk("latency",  lat, exp_lat);
        chk("bus_t1",   32'(bus1), 32'(exp_bus1));
        chk("nla_cnt",  nla_cnt, (arith || load) ? 1 : 0);
        chk("nlb_at",   nlb_at, arith ? 2 : 0);
        chk("eu_at",    eu_at, arith ? 3 : 0);
        chk("sub_cnt",  sub_cnt, (op == 3'd3) ? 1 : 0);
        chk("ea_cnt",   ea_cnt, (op == 3'd4) ? 1 : 0);
        chk("outsel",   os_cnt, (op == 3'd4) ? 1 : 0);
        if (op == 3'd4) chk("out_shown", 32'(shown), 32'(acc_ref));
        chk("acc",      32'(a_reg), 32'(acc_ref));
        chk("cf",       32'(cf), 32'(cf_ref));
        chk("zf",       32'(zf), 32'(zf_ref));
        chk("err",      32'(err), 32'(err_ref));
        tick();
        chk("done_once", 32'(done), 0);
        chk("ready_idle", 32'(cmd_if.cmd_ready), 1);
    endtask

    task automatic reset_refs();
        cf_ref = 1'b0; zf_ref = 1'b0; err_ref = 1'b0;
    endtask

    initial begin
        int dn, rdy, prev_rdy, consec;
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = '0;
        cmd_if.cmd_data  = '0;
        acc_ref = 8'h00;
        reset_refs();
        tick();
        tick();
        chk("rst_ready",  32'(cmd_if.cmd_ready), 0);
        chk("rst_ctrl",   32'(ctrl_word()), 32'(CTRL_IDLE));
        chk("rst_flags",  32'({done, cf, zf, err, halted}), 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(cmd_if.cmd_ready), 1);

        // Establish a known accumulator, then the directed cases
        run_cmd(3'd5, 8'h00);
        run_cmd(3'd1, 8'h05);
        run_cmd(3'd2, 8'h03);
        chk("acc_08", 32'(a_reg), 32'h08);
        run_cmd(3'd1, 8'h10);
        run_cmd(3'd3, 8'h10);
        chk("sub_zero", 32'({a_reg, zf}), 32'({8'h00, 1'b1}));
        run_cmd(3'd2, 8'hFF);
        run_cmd(3'd2, 8'h01);
        chk("wrap_flags", 32'({cf, zf}), 32'b11);
        run_cmd(3'd1, 8'hA5);
        run_cmd(3'd4, 8'h00);
        run_cmd(3'd5, 8'h77);
        chk("clr_keep_flags", 32'({a_reg, cf, zf}), 32'({8'h00, 1'b1, 1'b1}));
        run_cmd(3'd7, 8'h00);
        run_cmd(3'd0, 8'h00);
        chk("err_sticky", 32'(err), 1);

        // Randomized commands (HLT excluded)
        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 6);
            run_cmd((r == 6) ? 3'd7 : 3'(r), 8'($urandom));
        end

        // Backpressure: NOP held valid, one accept per IDLE visit
        wait_ready();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 3'd0;
        dn = 0; rdy = 0; consec = 0; prev_rdy = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) dn++;
            if (cmd_if.cmd_ready) rdy++;
            if (cmd_if.cmd_ready && prev_rdy == 1) consec++;
            prev_rdy = int'(cmd_if.cmd_ready);
        end
        cmd_if.cmd_valid = 1'b0;
        chk("bp_done", dn, 10);
        chk("bp_ready", rdy, 10);
        chk("bp_consec", consec, 0);
        tick();
        tick();

        // Abort: reset asserted during T2 of an ADD
        wait_ready();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 3'd2;
        cmd_if.cmd_data  = 8'h22;
        tick();
        cmd_if.cmd_valid = 1'b0;
        tick();
        chk("abort_t2_nlb", 32'(n_lb), 0);
        rst = 1'b1;
        #1;
        chk("abort_ready_rst", 32'(cmd_if.cmd_ready), 0);
        tick();
        chk("abort_no_done", 32'(done), 0);
        chk("abort_ctrl", 32'(ctrl_word()), 32'(CTRL_IDLE));
        rst = 1'b0;
        reset_refs();
        chk("abort_acc", 32'(a_reg), 32'(acc_ref));
        run_cmd(3'd2, 8'h01);

        // HLT: no done, ready held low with valid high, reset recovers
        run_cmd(3'd7, 8'h00);
        wait_ready();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 3'd6;
        tick();
        cmd_if.cmd_op = 3'd1;
        dn = 0; rdy = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dn++;
            if (cmd_if.cmd_ready) rdy++;
        end
        chk("hlt_halted", 32'(halted), 1);
        chk("hlt_no_done", dn, 0);
        chk("hlt_ready", rdy, 0);
        cmd_if.cmd_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        reset_refs();
        chk("hlt_cleared", 32'({halted, err}), 0);
        chk("hlt_ready_back", 32'(cmd_if.cmd_ready), 1);
        run_cmd(3'd1, 8'h3C);

        chk("exclusive_ctrl", viol, 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adder_sequencer.md
# adder_sequencer

Command-driven control sequencer for the 8-bit accumulator/B-register/ALU datapath. Accepts one command per valid/ready handshake and drives the datapath strobes cycle by cycle: `n_la`, `n_lb`, `e_a`, `e_u`, `sub` and `out_sel`. It also supplies the operand that the datapath input buffer registers. It replaces manual strobing of the datapath from pins and latches the ALU carry/zero flags after arithmetic.

## Interface
Parameters: none.

- `clk` in 1 — single clock; all logic on posedge.
- `rst` in 1 — synchronous, active-high reset.
- `cmd_valid` in 1 — command present.
- `cmd_ready` out 1 — sequencer can accept a command.
- `cmd_op` in 3 — opcode, sampled on accept.
- `cmd_data` in 8 — immediate operand, sampled on accept.
- `cf_in` in 1 — ALU carry, valid while `e_u`=1.
- `zf_in` in 1 — ALU zero, valid while `e_u`=1.
- `bus_data` out 8 — operand to datapath input buffer (registered there, 1-cycle latency).
- `n_la` out 1 — accumulator load, active low.
- `n_lb` out 1 — B register load, active low.
- `e_a` out 1 — accumulator drives bus.
- `e_u` out 1 — ALU drives bus.
- `sub` out 1 — ALU subtract select.
- `out_sel` out 1 — output mux shows bus (1) or accumulator (0).
- `done` out 1 — one-cycle pulse when a command completes.
- `cf` out 1 — latched carry flag.
- `zf` out 1 — latched zero flag.
- `err` out 1 — sticky, set by an illegal opcode.
- `halted` out 1 — sequencer stopped by HLT.

## Operation
- **Opcodes:**
  - 000 NOP
  - 001 LDA (A←imm)
  - 010 ADD (A←A+imm)
  - 011 SUB (A←A−imm)
  - 100 OUT (show A on bus)
  - 101 CLR (A←0)
  - 110 HLT
  - 111 illegal
- **States:** IDLE, T1, T2, T3, DONE, HALT.
- **Accept:** on the posedge where `cmd_valid`&`cmd_ready`, op and data are latched; IDLE→T1.
- **`cmd_ready`** = (state==IDLE) & !`rst`. `cmd_valid` is ignored while `cmd_ready`=0.
- **Inactive control word** (every state/cycle not listed below): `n_la`=1, `n_lb`=1, `e_a`=0, `e_u`=0, `sub`=0, `out_sel`=0, `bus_data`=0.
- **Per-op sequences** (listed cycles only):
  - NOP: T1 (inactive) → DONE.
  - LDA: T1 `bus_data`=imm → T2 `n_la`=0 → DONE.
  - CLR: T1 `bus_data`=0 → T2 `n_la`=0 → DONE.
  - ADD/SUB: T1 `bus_data`=imm → T2 `n_lb`=0 → T3 `e_u`=1, `n_la`=0, `sub`=(op==SUB) → DONE.
  - OUT: T1 `e_a`=1, `out_sel`=1 → DONE.
  - HLT: T1 → HALT. No `done` pulse; `halted`=1; `cmd_ready`=0 until `rst`.
  - Illegal: as NOP; `err` set at end of T1.
- **Flags:** `cf`/`zf` load from `cf_in`/`zf_in` at the end of T3 only. LDA, CLR, OUT and NOP leave the flags unchanged.
- **DONE:** `done`=1 for one cycle, then → IDLE.
- **Arithmetic:** performed by the ALU; the sequencer does no arithmetic. SUB is A−imm modulo 256; `cf` reports whatever the ALU reports.

## Timing
- **Reset**, applied on any posedge with `rst`=1, regardless of state:
  - state→IDLE;
  - `cf`=0, `zf`=0, `err`=0, `halted`=0, `done`=0;
  - control word inactive.
  - `cmd_ready` is 0 while `rst` is high and 1 on the first cycle after.
- **Reset mid-command:** aborts the command at that edge; no `done`. Datapath register contents are not restored by the sequencer.
- **Latency** (accept edge to `done` cycle, inclusive):
  - NOP/OUT/illegal: 2 cycles;
  - LDA/CLR: 3 cycles;
  - ADD/SUB: 4 cycles.
  - Next accept is possible on the cycle after DONE (IDLE). Throughput is one ADD per 5 cycles.
- **Operand path:** `bus_data` in T1 is registered by the input buffer at the end of T1 and is on the bus during T2. Loads occur at the end of the cycle in which `n_la`/`n_lb`=0.
- `e_a` and `e_u` are never both 1. `n_la` and `n_lb` are never both 0.
- `cmd_op`/`cmd_data` may change freely after acceptance.
- All outputs are registered or decoded from registered state. No output depends combinationally on `cmd_*` except `cmd_ready` (which depends on `rst`).

## Test plan
- **Reset:** `rst` for 2 cycles → all outputs at reset values; `cmd_ready` rises the cycle after `rst` falls.
- **LDA/ADD:** LDA 0x05, then ADD 0x03 → accumulator 0x08; `cf`=0, `zf`=0; `done` 3 and 4 cycles after the respective accepts; `n_lb` low exactly in T2 of the ADD.
- **SUB:** LDA 0x10, SUB 0x10 → accumulator 0x00, `zf`=1; ADD 0xFF then ADD 0x01 from A=0x00 → `cf`=1, `zf`=1.
- **OUT/CLR:** OUT after LDA 0xA5 → `e_a`=`out_sel`=1 for exactly one cycle, output shows 0xA5. CLR → accumulator 0x00, flags unchanged.
- **Illegal/HLT:** op 111 → `err`=1, `done` pulses, `err` stays 1. HLT → `halted`=1, `cmd_ready`=0 with `cmd_valid` held high for 10 cycles; `rst` clears both.
- **Abort/backpressure:** assert `rst` in T2 of an ADD → no `done`, controls inactive the next cycle. `cmd_valid` held high back-to-back → exactly one accept per IDLE visit.
